// File: rtl/phase_acc_par.sv
// phase_acc_par: multi-lane NCO phase generator.
// Emits LANES consecutive phase samples per clock with valid/ready backpressure.
// A shadow config register provides phase-continuous retuning. The block also
// supports a programmable phase offset, phase sync, and linear-sweep (chirp) mode.
module phase_acc_par #(
    parameter int unsigned PW    = 32,
    parameter int unsigned LANES = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                sync_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [PW-1:0]       cfg_inc_i,
    input  logic [PW-1:0]       cfg_ofs_i,
    input  logic [PW-1:0]       cfg_step_i,
    input  logic                cfg_sweep_i,
    output logic [LANES*PW-1:0] phase_o,
    output logic                valid_o,
    input  logic                ready_i
);

    logic [PW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       inc_q, inc_d;
    logic [PW-1:0]       ofs_q, ofs_d;
    logic [PW-1:0]       step_q, step_d;
    logic                sweep_q, sweep_d;
    logic [PW-1:0]       sh_inc_q, sh_inc_d;
    logic [PW-1:0]       sh_ofs_q, sh_ofs_d;
    logic [PW-1:0]       sh_step_q, sh_step_d;
    logic                sh_sweep_q, sh_sweep_d;
    logic                pend_q, pend_d;
    logic                sync_pend_q, sync_pend_d;
    logic [LANES*PW-1:0] phase_q, phase_d;
    logic                valid_q, valid_d;

    logic                load;
    logic                cfg_acc;
    logic [PW-1:0]       eff_inc, eff_ofs, eff_step, base;
    logic                eff_sweep;

    assign cfg_ready_o = ~pend_q;
    assign phase_o     = phase_q;
    assign valid_o     = valid_q;
    assign load        = en_i & (~valid_q | ready_i);
    assign cfg_acc     = cfg_valid_i & ~pend_q;

    // Next-state logic. A load consumes the shadow before a same-cycle
    // config write refills it, so that write lands at the following load.
    always_comb begin
        acc_d       = acc_q;
        inc_d       = inc_q;
        ofs_d       = ofs_q;
        step_d      = step_q;
        sweep_d     = sweep_q;
        sh_inc_d    = sh_inc_q;
        sh_ofs_d    = sh_ofs_q;
        sh_step_d   = sh_step_q;
        sh_sweep_d  = sh_sweep_q;
        pend_d      = pend_q;
        sync_pend_d = sync_pend_q;
        phase_d     = phase_q;
        valid_d     = valid_q;

        eff_inc   = pend_q ? sh_inc_q   : inc_q;
        eff_ofs   = pend_q ? sh_ofs_q   : ofs_q;
        eff_step  = pend_q ? sh_step_q  : step_q;
        eff_sweep = pend_q ? sh_sweep_q : sweep_q;
        base      = (sync_i | sync_pend_q) ? '0 : acc_q;

        if (load) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                phase_d[k*PW +: PW] = base + eff_ofs + PW'(k) * eff_inc;
            end
            acc_d       = base + PW'(LANES) * eff_inc;
            inc_d       = eff_sweep ? eff_inc + eff_step : eff_inc;
            ofs_d       = eff_ofs;
            step_d      = eff_step;
            sweep_d     = eff_sweep;
            pend_d      = 1'b0;
            sync_pend_d = 1'b0;
            valid_d     = 1'b1;
        end else begin
            if (sync_i) sync_pend_d = 1'b1;
            if (valid_q & ready_i) valid_d = 1'b0;
        end

        if (cfg_acc) begin
            sh_inc_d   = cfg_inc_i;
            sh_ofs_d   = cfg_ofs_i;
            sh_step_d  = cfg_step_i;
            sh_sweep_d = cfg_sweep_i;
            pend_d     = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            inc_q       <= '0;
            ofs_q       <= '0;
            step_q      <= '0;
            sweep_q     <= 1'b0;
            sh_inc_q    <= '0;
            sh_ofs_q    <= '0;
            sh_step_q   <= '0;
            sh_sweep_q  <= 1'b0;
            pend_q      <= 1'b0;
            sync_pend_q <= 1'b0;
            phase_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            ofs_q       <= ofs_d;
            step_q      <= step_d;
            sweep_q     <= sweep_d;
            sh_inc_q    <= sh_inc_d;
            sh_ofs_q    <= sh_ofs_d;
            sh_step_q   <= sh_step_d;
            sh_sweep_q  <= sh_sweep_d;
            pend_q      <= pend_d;
            sync_pend_q <= sync_pend_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
        end
    end

endmodule
